// File: rtl/tc_pipe_multiplier.sv
// Fully pipelined signed/unsigned multiplier with valid/ready backpressure,
// bubble collapsing, tag passthrough and flush. TC_MUL_PERF_CNT_EN adds perf counters.
module tc_pipe_multiplier #(
  parameter int LEN    = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [LEN-1:0]       in_a,
  input  logic [LEN-1:0]       in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*LEN-1:0]     out_result,
  output logic [TAG_W-1:0]     out_tag
`ifdef TC_MUL_PERF_CNT_EN
  ,
  output logic [31:0]          perf_ops,
  output logic [31:0]          perf_stall
`endif
);

  logic [STAGES:1]    valid;
  logic [2*LEN-1:0]   data [1:STAGES];
  logic [TAG_W-1:0]   tag  [1:STAGES];
  logic [STAGES:1]    ready;
  logic [STAGES:1]    src_valid;
  logic [2*LEN-1:0]   src_data [1:STAGES];
  logic [TAG_W-1:0]   src_tag  [1:STAGES];
  logic [2*LEN-1:0]   ext_a;
  logic [2*LEN-1:0]   ext_b;
  logic [2*LEN-1:0]   product;

  // Sign/zero extension to 2*LEN makes one unsigned multiply serve both modes.
  assign ext_a   = {{LEN{in_signed & in_a[LEN-1]}}, in_a};
  assign ext_b   = {{LEN{in_signed & in_b[LEN-1]}}, in_b};
  assign product = ext_a * ext_b;

  always_comb begin
    logic r;
    ready = '0;
    r = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      r        = !valid[k] | r;
      ready[k] = r;
    end
  end

  assign in_ready = ready[1] & !flush & rst_n;

  always_comb begin
    src_valid    = '0;
    src_valid[1] = in_valid & in_ready;
    src_data[1]  = product;
    src_tag[1]   = in_tag;
    for (int k = 2; k <= STAGES; k++) begin
      src_valid[k] = valid[k-1];
      src_data[k]  = data[k-1];
      src_tag[k]   = tag[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        data[k] <= '0;
        tag[k]  <= '0;
      end
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (flush)
          valid[k] <= 1'b0;
        else if (ready[k])
          valid[k] <= src_valid[k];
        // Payload only moves with a real operation; bubbles leave stale data behind.
        if (ready[k] && src_valid[k]) begin
          data[k] <= src_data[k];
          tag[k]  <= src_tag[k];
        end
      end
    end
  end

  assign out_valid  = valid[STAGES];
  assign out_result = data[STAGES];
  assign out_tag    = tag[STAGES];

`ifdef TC_MUL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else if (flush) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid && out_ready)
        perf_ops <= perf_ops + 32'd1;
      if (out_valid && !out_ready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tc_pipe_multiplier.sv
// Directed bench for tc_pipe_multiplier: a 32-bit/3-stage instance and an 8-bit/1-stage instance.
module tb_tc_pipe_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        flush, in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic [7:0]  in_tag, out_tag;
  logic [63:0] out_result;

  logic        b_flush, b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
  logic [7:0]  b_in_a, b_in_b;
  logic [3:0]  b_in_tag, b_out_tag;
  logic [15:0] b_out_result;

`ifdef TC_MUL_PERF_CNT_EN
  logic [31:0] a_perf_ops, a_perf_stall, b_perf_ops, b_perf_stall;
`endif

  tc_pipe_multiplier #(.LEN(32), .STAGES(3), .TAG_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
`ifdef TC_MUL_PERF_CNT_EN
    , .perf_ops(a_perf_ops), .perf_stall(a_perf_stall)
`endif
  );

  tc_pipe_multiplier #(.LEN(8), .STAGES(1), .TAG_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_signed(b_in_signed),
    .in_a(b_in_a), .in_b(b_in_b), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_result(b_out_result), .out_tag(b_out_tag)
`ifdef TC_MUL_PERF_CNT_EN
    , .perf_ops(b_perf_ops), .perf_stall(b_perf_stall)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_res[$];
  logic [7:0]  exp_tag[$];

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [7:0] t);
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t;
  endtask

  task automatic drain(input int n, input string name);
    int got;
    got = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && got < n; c++) begin
      @(negedge clk);
      if (out_valid && exp_res.size() > 0) begin
        check_val({name, "_res"}, out_result, exp_res.pop_front());
        check_val({name, "_tag"}, {56'd0, out_tag}, {56'd0, exp_tag.pop_front()});
        got++;
      end
      step();
    end
    check_val({name, "_count"}, 64'(got), 64'(n));
  endtask

  task automatic quiet(input int n, input string name);
    int seen;
    seen = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
      step();
    end
    check_val(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int next, rcv;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_signed = 1'b0;
    b_in_a = '0; b_in_b = '0; b_in_tag = '0; b_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_out_result", out_result, 64'd0);
    check_val("rst_out_tag", {56'd0, out_tag}, 64'd0);
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_val("rst_b_out_valid", {63'd0, b_out_valid}, 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rel_in_ready", {63'd0, in_ready}, 64'd1);
    step();

    // Unsigned max with 3-cycle latency
    put(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 8'h5A);
    @(negedge clk);
    check_val("umax_in_ready", {63'd0, in_ready}, 64'd1);
    step(); in_valid = 1'b0;
    @(negedge clk); check_val("umax_lat1", {63'd0, out_valid}, 64'd0);
    step();
    @(negedge clk); check_val("umax_lat2", {63'd0, out_valid}, 64'd0);
    step();
    @(negedge clk);
    check_val("umax_valid", {63'd0, out_valid}, 64'd1);
    check_val("umax_res", out_result, 64'hFFFF_FFFE_0000_0001);
    check_val("umax_tag", {56'd0, out_tag}, 64'h5A);
    step();
    @(negedge clk); check_val("umax_gone", {63'd0, out_valid}, 64'd0);
    step();

    // Signed vs unsigned back-to-back
    put(32'hFFFF_FFFF, 32'd2, 1'b1, 8'h11); step();
    put(32'hFFFF_FFFF, 32'd2, 1'b0, 8'h22); step();
    in_valid = 1'b0; step();
    @(negedge clk);
    check_val("smix_v1", {63'd0, out_valid}, 64'd1);
    check_val("smix_r1", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
    check_val("smix_t1", {56'd0, out_tag}, 64'h11);
    step();
    @(negedge clk);
    check_val("smix_v2", {63'd0, out_valid}, 64'd1);
    check_val("smix_r2", out_result, 64'h0000_0001_FFFF_FFFE);
    check_val("smix_t2", {56'd0, out_tag}, 64'h22);
    step();

    // Backpressure: 6 ops, out_ready low for the first 6 cycles
    next = 0; rcv = 0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid = (next < 6); in_a = 32'(next); in_b = 32'(next + 1);
      in_signed = 1'b0; in_tag = 8'(next);
      @(negedge clk);
      if (cyc < 6)
        check_val($sformatf("bp_in_ready_c%0d", cyc), {63'd0, in_ready}, (cyc < 3) ? 64'd1 : 64'd0);
      if (cyc >= 3 && cyc < 6) begin
        check_val($sformatf("bp_hold_v_c%0d", cyc), {63'd0, out_valid}, 64'd1);
        check_val($sformatf("bp_hold_r_c%0d", cyc), out_result, 64'd0);
      end
      if (in_valid && in_ready) next++;
      if (out_valid && out_ready) begin
        check_val($sformatf("bp_res%0d", rcv), out_result, 64'(rcv * (rcv + 1)));
        check_val($sformatf("bp_tag%0d", rcv), {56'd0, out_tag}, 64'(rcv));
        rcv++;
      end
      step();
    end
    in_valid = 1'b0;
    check_val("bp_count", 64'(rcv), 64'd6);
    quiet(4, "bp_no_dup");

    // Bubble collapse while stage 3 is stalled
    out_ready = 1'b0;
    put(32'd7, 32'd9, 1'b0, 8'hA1); exp_res.push_back(64'd63); exp_tag.push_back(8'hA1);
    step(); in_valid = 1'b0;
    step(); step();
    put(32'd3, 32'd5, 1'b0, 8'hB2);
    @(negedge clk);
    check_val("bub_stall_v", {63'd0, out_valid}, 64'd1);
    check_val("bub_stall_r", out_result, 64'd63);
    check_val("bub_acc1", {63'd0, in_ready}, 64'd1);
    exp_res.push_back(64'd15); exp_tag.push_back(8'hB2);
    step();
    put(32'd100, 32'd200, 1'b0, 8'hC3);
    @(negedge clk);
    check_val("bub_acc2", {63'd0, in_ready}, 64'd1);
    exp_res.push_back(64'd20000); exp_tag.push_back(8'hC3);
    step();
    put(32'd1, 32'd1, 1'b0, 8'hD4);
    @(negedge clk);
    check_val("bub_full", {63'd0, in_ready}, 64'd0);
    check_val("bub_still_r", out_result, 64'd63);
    step();
    drain(3, "bub");
    quiet(3, "bub_quiet");

    // Flush with in_valid asserted
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(32'(i + 2), 32'd3, 1'b0, 8'(i)); step();
    end
    flush = 1'b1; put(32'd9, 32'd9, 1'b0, 8'hEE);
    @(negedge clk);
    check_val("fl_in_ready", {63'd0, in_ready}, 64'd0);
    check_val("fl_pending", out_result, 64'd6);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_val("fl_out_valid", {63'd0, out_valid}, 64'd0);
    step();
    quiet(6, "fl_no_stale");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      put(32'(i + 1), 32'd5, 1'b0, 8'(i)); step();
    end
    in_valid = 1'b0;
    check_val("ar_pre_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("ar_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("ar_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("ar_rel_ready", {63'd0, in_ready}, 64'd1);
    step();
    quiet(6, "ar_no_stale");

    // Single-stage 8-bit instance
    b_in_valid = 1'b1; b_in_a = 8'h80; b_in_b = 8'h80; b_in_signed = 1'b1; b_in_tag = 4'h1;
    @(negedge clk);
    check_val("s1_in_ready", {63'd0, b_in_ready}, 64'd1);
    step();
    b_in_a = 8'hFF; b_in_b = 8'hFF; b_in_signed = 1'b0; b_in_tag = 4'h2;
    @(negedge clk);
    check_val("s1_v1", {63'd0, b_out_valid}, 64'd1);
    check_val("s1_r1", {48'd0, b_out_result}, 64'h4000);
    check_val("s1_t1", {60'd0, b_out_tag}, 64'h1);
    step();
    b_in_signed = 1'b1; b_in_tag = 4'h3;
    @(negedge clk);
    check_val("s1_r2", {48'd0, b_out_result}, 64'hFE01);
    step();
    b_in_a = 8'h7F; b_in_b = 8'h80; b_in_tag = 4'h4;
    @(negedge clk);
    check_val("s1_r3", {48'd0, b_out_result}, 64'h0001);
    step();
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    @(negedge clk);
    check_val("s1_r4", {48'd0, b_out_result}, 64'hC080);
    check_val("s1_stall_ready", {63'd0, b_in_ready}, 64'd0);
    step();
    @(negedge clk);
    check_val("s1_hold_v", {63'd0, b_out_valid}, 64'd1);
    check_val("s1_hold_r", {48'd0, b_out_result}, 64'hC080);
    step();
    b_out_ready = 1'b1;
    @(negedge clk);
    check_val("s1_t4", {60'd0, b_out_tag}, 64'h4);
    step();
    @(negedge clk);
    check_val("s1_done", {63'd0, b_out_valid}, 64'd0);
`ifdef TC_MUL_PERF_CNT_EN
    check_val("perf_ops", {32'd0, b_perf_ops}, 64'd4);
    check_val("perf_stall", {32'd0, b_perf_stall}, 64'd2);
    step();
    b_flush = 1'b1; step(); b_flush = 1'b0;
    @(negedge clk);
    check_val("perf_flush_ops", {32'd0, b_perf_ops}, 64'd0);
    check_val("perf_flush_stall", {32'd0, b_perf_stall}, 64'd0);
`endif
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
